// File: rtl/wb_pkg.sv
// Shared types for the L1 write buffer: memory-port FSM states and the
// buffered write entry layout.
package wb_pkg;

  typedef enum logic [1:0] {
    MIDLE  = 2'd0,
    MWRITE = 2'd1,
    MREAD  = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending cache writes.
// With WB_FORWARD_EN defined, also provides a youngest-match address lookup
// across all valid entries so reads can be served from the buffer.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head_entry,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
`ifdef WB_FORWARD_EN
  ,
  input  logic [31:0]      lookup_addr,
  output logic             hit,
  output logic [31:0]      hit_data
`endif
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry storage; stale contents are harmless since count gates validity.
  always_ff @(posedge clock) begin
    if (push) mem[tail] <= push_entry;
  end

  assign head_entry = mem[head];
  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);

`ifdef WB_FORWARD_EN
  // Scan oldest to youngest so the last match wins (youngest write).
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (mem[head + PTR_W'(i)].addr == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = mem[head + PTR_W'(i)].data;
      end
    end
  end
`endif

endmodule

// File: rtl/l1_write_buffer.sv
// L1 write buffer: queues cache writes and drains them to memory, serves
// cache reads through the memory port.
// Optional feature macro: WB_FORWARD_EN (read forwarding from buffered
// writes; read misses may bypass queued writes). Without it, reads wait for
// the buffer to drain, keeping strict ordering.
//
// state  | meaning
// MIDLE  | memory port idle, enableToMem low
// MWRITE | head entry driven to memory as a write, waiting readyFromMem
// MREAD  | latched read address driven to memory, waiting readyFromMem
module l1_write_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addrFromL1,
  input  logic        enableFromL1,
  input  logic        writeFromL1,
  input  logic [31:0] dataFromL1,
  output logic [31:0] dataToL1,
  output logic        readyToL1,
  output logic [31:0] addrToMem,
  output logic        enableToMem,
  output logic        writeToMem,
  output logic [31:0] dataToMem,
  input  logic [31:0] dataFromMem,
  input  logic        readyFromMem,
  output logic        wbFull,
  output logic        wbEmpty
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  mem_state_t       state;
  logic             read_pending;
  logic [31:0]      read_addr;
  wb_entry_t        push_entry;
  wb_entry_t        head_entry;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             req_idle;
  logic             accept_write;
  logic             accept_read;
  logic             read_miss;
  logic             read_go;
  logic             fwd_hit;
  logic [31:0]      fwd_data;
  logic             pop;
  logic             mem_read_done;

  // A request is only considered when the previous one has fully completed.
  assign req_idle      = enableFromL1 && !readyToL1 && !read_pending;
  assign accept_write  = req_idle && writeFromL1 && !fifo_full;
  assign accept_read   = req_idle && !writeFromL1;
  assign pop           = (state == MWRITE) && readyFromMem;
  assign mem_read_done = (state == MREAD) && readyFromMem;
  assign push_entry    = '{addr: addrFromL1, data: dataFromL1};

`ifdef WB_FORWARD_EN
  logic fwd_match;
  assign fwd_hit   = accept_read && fwd_match;
  assign read_miss = accept_read && !fwd_match;
  assign read_go   = 1'b1;
`else
  assign fwd_hit   = 1'b0;
  assign fwd_data  = '0;
  assign read_miss = accept_read;
  assign read_go   = fifo_empty;
`endif

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (accept_write),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (count),
    .full       (fifo_full),
    .empty      (fifo_empty)
`ifdef WB_FORWARD_EN
    ,
    .lookup_addr(addrFromL1),
    .hit        (fwd_match),
    .hit_data   (fwd_data)
`endif
  );

  assign wbFull  = fifo_full;
  assign wbEmpty = (count == '0);

  // Memory-port FSM with registered memory and cache-side outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= MIDLE;
      enableToMem  <= 1'b0;
      writeToMem   <= 1'b0;
      addrToMem    <= '0;
      dataToMem    <= '0;
      dataToL1     <= '0;
      readyToL1    <= 1'b0;
      read_pending <= 1'b0;
      read_addr    <= '0;
    end else begin
      readyToL1 <= accept_write || fwd_hit || mem_read_done;
      if (fwd_hit) dataToL1 <= fwd_data;
      if (read_miss) begin
        read_pending <= 1'b1;
        read_addr    <= addrFromL1;
      end
      case (state)
        MIDLE: begin
          if (read_pending && read_go) begin
            state       <= MREAD;
            enableToMem <= 1'b1;
            writeToMem  <= 1'b0;
            addrToMem   <= read_addr;
          end else if (!fifo_empty) begin
            state       <= MWRITE;
            enableToMem <= 1'b1;
            writeToMem  <= 1'b1;
            addrToMem   <= head_entry.addr;
            dataToMem   <= head_entry.data;
          end
        end
        MWRITE: begin
          if (readyFromMem) begin
            state       <= MIDLE;
            enableToMem <= 1'b0;
            writeToMem  <= 1'b0;
          end
        end
        MREAD: begin
          if (readyFromMem) begin
            state        <= MIDLE;
            enableToMem  <= 1'b0;
            dataToL1     <= dataFromMem;
            read_pending <= 1'b0;
          end
        end
        default: begin
          state       <= MIDLE;
          enableToMem <= 1'b0;
          writeToMem  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/l1_write_buffer.md
L1_WRITE_BUFFER -- requirements
Module: l1_write_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of buffered write entries (power of two, at least 2).
REQ-002 The block SHALL have input clock, 1 bit, the clock.
REQ-003 The block SHALL have input reset, 1 bit, the reset: asynchronous, active-high.
REQ-004 The block SHALL have input addrFromL1, 32 bits, the cache-side word address.
REQ-005 The block SHALL have input enableFromL1, 1 bit, the cache-side request valid.
REQ-006 The block SHALL have input writeFromL1, 1 bit, the cache-side direction (0 read, 1 write).
REQ-007 The block SHALL have input dataFromL1, 32 bits, the cache-side write data.
REQ-008 The block SHALL have output dataToL1, 32 bits, the read data returned to the cache.
REQ-009 The block SHALL have output readyToL1, 1 bit, a one-cycle completion pulse to the cache.
REQ-010 The block SHALL have outputs addrToMem (32 bits), enableToMem (1 bit), writeToMem (1 bit) and dataToMem (32 bits), forming the memory-side request.
REQ-011 The block SHALL have inputs dataFromMem (32 bits) and readyFromMem (1 bit), the memory-side response.
REQ-012 The block SHALL have outputs wbFull and wbEmpty, 1 bit each, reporting buffer status.

Function
REQ-013 Handshake, both sides SHALL follow these rules:
- The requester holds address, data and direction stable while its enable is high.
- A transaction completes in the cycle its ready is sampled high.
REQ-014 A cache write SHALL be accepted when all of the following hold: enableFromL1=1, writeFromL1=1, count<DEPTH, readyToL1=0 and no cache read is outstanding.
- On acceptance, {addr, data} is enqueued at the tail.
- readyToL1 pulses for exactly 1 cycle, on the cycle after acceptance.
REQ-015 When a cache write arrives at count==DEPTH, it SHALL be stalled, even if a pop occurs in the same cycle; acceptance happens on a later cycle.
REQ-016 No cache request SHALL be accepted in a cycle where readyToL1=1, so that a held request is not accepted twice.
REQ-017 The memory-port FSM SHALL have three states:
- MIDLE: enableToMem=0.
- MWRITE: drives the head entry with writeToMem=1.
- MREAD: drives the latched read address with writeToMem=0.
REQ-018 The memory-port FSM SHALL make these transitions:
- MIDLE->MREAD when a read miss is pending (takes priority).
- Otherwise MIDLE->MWRITE when count>0.
- MWRITE->MIDLE on readyFromMem, popping the head.
- MREAD->MIDLE on readyFromMem, registering dataFromMem into dataToL1 and pulsing readyToL1 on the next cycle.
REQ-019 Memory-side outputs SHALL be driven from registers and SHALL remain stable in MWRITE/MREAD until readyFromMem.
REQ-020 Head and tail pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; count SHALL be $clog2(DEPTH+1) bits.
REQ-021 wbEmpty SHALL equal (count==0) and wbFull SHALL equal (count==DEPTH).
REQ-022 If an enqueue and a pop occur in the same cycle, count SHALL be unchanged.
REQ-023 dataToL1 SHALL hold its last value, and SHALL be valid only while readyToL1=1.

Reset
REQ-024 On reset, the block SHALL take these values:
- count=0; head and tail pointers = 0.
- FSM=MIDLE.
- readyToL1=0, enableToMem=0, writeToMem=0.
- addrToMem, dataToMem and dataToL1 all 0.
- wbEmpty=1, wbFull=0.
REQ-025 Reset asserted mid-transaction SHALL discard all buffered entries and any in-flight read, with no completion pulse.

Configuration
REQ-026 When WB_FORWARD_EN is defined, a cache read SHALL compare addrFromL1 against all valid entries.
- On a hit, the youngest matching entry's data is returned with readyToL1 one cycle later and no memory access.
- On a miss, the read becomes pending and may bypass queued writes.
REQ-027 When WB_FORWARD_EN is undefined, a cache read SHALL stay pending until count==0 and the FSM is in MIDLE before entering MREAD, which gives strict ordering.

Structure
REQ-028 Package wb_pkg SHALL hold the mem_state_t enum (MIDLE/MWRITE/MREAD) and the wb_entry_t struct {addr[31:0], data[31:0]}.
REQ-029 Sub-module wb_fifo SHALL implement the circular buffer:
- push, pop, head output, count, full/empty;
- under WB_FORWARD_EN, an associative youngest-match lookup.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Write 0x100<-0xAAAA0001 with readyFromMem held 0 -> readyToL1 pulses on cycle 2; enableToMem=1, addrToMem=0x100, writeToMem=1; count=1.
- 5 writes with DEPTH=4 and memory stalled -> 4 accepted, wbFull=1; the 5th stalls until the first readyFromMem, then is accepted.
- With WB_FORWARD_EN: write 0x200<-0x11, write 0x200<-0x22, read 0x200 with memory stalled -> dataToL1=0x22 one cycle later; no MREAD.
- Without WB_FORWARD_EN: 2 queued writes, then read 0x300 -> MREAD starts only after both pops; dataToL1=dataFromMem one cycle after readyFromMem.
- Reset mid-MWRITE with count=3 -> enableToMem=0, count=0, wbEmpty=1 immediately; no readyToL1 pulse.
- Back-to-back held write -> accepted exactly once, and count increments by 1 only.
